// File: rtl/kart_race_core.sv
// kart_race_core: race state machine, local kart motion and remote opponent tracking.
// All motion and race timing advance on a frame tick taken from the raster position.
// Optional build macro KART_COLLISION_EN: a kart touching a live opponent stops dead
// for that tick instead of moving.
//
// state     | meaning
// ----------+-------------------------------------------------------------
// S_IDLE    | waiting for accelerate on a tick or a remote start request
// S_COUNT   | countdown of COUNT_FRAMES ticks, kart frozen
// S_RACE    | kart steers, accelerates and moves on every tick
// S_WON     | local kart completed LAPS laps first
// S_LOST    | a remote opponent reported a win
module kart_race_core #(
  parameter int NUM_OPP      = 2,
  parameter int POS_W        = 11,
  parameter int TICK_H       = 1279,
  parameter int TICK_V       = 719,
  parameter int COUNT_FRAMES = 180,
  parameter int MAX_SPEED    = 4,
  parameter int LAPS         = 3,
  parameter int STALE_FRAMES = 30
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     btnu,
  input  logic [15:0]              sw,
  input  logic [10:0]              hcount,
  input  logic [9:0]               vcount,
  input  logic [NUM_OPP-1:0]       r_opp_valid,
  input  logic [NUM_OPP*POS_W-1:0] r_opp_x,
  input  logic [NUM_OPP*POS_W-1:0] r_opp_y,
  input  logic [NUM_OPP*9-1:0]     r_opp_dir,
  input  logic [NUM_OPP*3-1:0]     r_opp_game,
  input  logic [NUM_OPP-1:0]       r_opp_rst,
  output logic [POS_W-1:0]         player_x,
  output logic [POS_W-1:0]         player_y,
  output logic [8:0]               player_direction,
  output logic [2:0]               player_speed,
  output logic [NUM_OPP*POS_W-1:0] opponent_x,
  output logic [NUM_OPP*POS_W-1:0] opponent_y,
  output logic [NUM_OPP-1:0]       opp_stale,
  output logic [1:0]               lap_count,
  output logic [2:0]               game_stat
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_COUNT = 3'd1,
    S_RACE  = 3'd2,
    S_WON   = 3'd3,
    S_LOST  = 3'd4
  } state_t;

  localparam int CD_W = $clog2(COUNT_FRAMES + 1);
  localparam int ST_W = $clog2(STALE_FRAMES + 1);

  localparam logic [10:0]      TICK_H_L  = 11'(TICK_H);
  localparam logic [9:0]       TICK_V_L  = 10'(TICK_V);
  localparam logic [POS_W-1:0] START_X   = POS_W'(400);
  localparam logic [POS_W-1:0] START_Y   = POS_W'(400);
  localparam logic [8:0]       START_DIR = 9'd90;
  localparam logic [2:0]       MAX_SPD   = 3'(MAX_SPEED);
  localparam logic [2:0]       LAPS_L    = 3'(LAPS);
  localparam logic [POS_W-1:0] LAP_Y     = POS_W'(360);
  localparam logic [POS_W-1:0] LAP_X_LO  = POS_W'(300);
  localparam logic [POS_W-1:0] LAP_X_HI  = POS_W'(500);
  localparam logic signed [POS_W+1:0] POS_MAX = {2'b00, {POS_W{1'b1}}};

  state_t                  state;
  logic [CD_W-1:0]         cd_cnt;
  logic [ST_W-1:0]         stale_cnt [NUM_OPP];

  logic                    tick;
  logic                    any_go;
  logic                    any_lost;
  logic [8:0]              dir_next;
  logic [2:0]              spd_next;
  logic [9:0]              dir_adj;
  logic [2:0]              sector;
  logic signed [POS_W+1:0] spd_s;
  logic signed [POS_W+1:0] dx;
  logic signed [POS_W+1:0] dy;
  logic signed [POS_W+1:0] nx;
  logic signed [POS_W+1:0] ny;
  logic [POS_W-1:0]        x_moved;
  logic [POS_W-1:0]        y_moved;
  logic [POS_W-1:0]        race_x;
  logic [POS_W-1:0]        race_y;
  logic [2:0]              race_spd;
  logic                    lap_hit;
  logic                    win;
  logic                    unused_in;

  // direction of remote karts and the upper switches are not used by this core
  assign unused_in = ^{sw[15:2], r_opp_dir};

  assign tick      = (hcount == TICK_H_L) && (vcount == TICK_V_L);
  assign game_stat = state;

  // any remote channel asking for a start or reporting its own win
  always_comb begin
    any_go   = 1'b0;
    any_lost = 1'b0;
    for (int i = 0; i < NUM_OPP; i++) begin
      if (r_opp_game[i*3 +: 3] == 3'd1) any_go = 1'b1;
      if (r_opp_game[i*3 +: 3] == 3'd3) any_lost = 1'b1;
    end
  end

  // heading and speed candidates for the next race tick
  always_comb begin
    dir_next = player_direction;
    case (sw[1:0])
      2'b01:   dir_next = (player_direction >= 9'd355) ? player_direction - 9'd355
                                                       : player_direction + 9'd5;
      2'b10:   dir_next = (player_direction < 9'd5) ? player_direction + 9'd355
                                                    : player_direction - 9'd5;
      default: dir_next = player_direction;
    endcase
    if (btnu) spd_next = (player_speed >= MAX_SPD) ? MAX_SPD : player_speed + 3'd1;
    else      spd_next = (player_speed == 3'd0) ? 3'd0 : player_speed - 3'd1;
  end

  // displacement from the current heading sector and current speed, clamped to the field
  always_comb begin
    dir_adj = {1'b0, player_direction} + 10'd22;
    sector  = 3'(dir_adj / 10'd45);
    spd_s   = $signed({{(POS_W-1){1'b0}}, player_speed});
    dx      = '0;
    dy      = '0;
    case (sector)
      3'd0: dx = spd_s;
      3'd1: begin dx = spd_s;  dy = -spd_s; end
      3'd2: dy = -spd_s;
      3'd3: begin dx = -spd_s; dy = -spd_s; end
      3'd4: dx = -spd_s;
      3'd5: begin dx = -spd_s; dy = spd_s;  end
      3'd6: dy = spd_s;
      default: begin dx = spd_s; dy = spd_s; end
    endcase
    nx = $signed({2'b00, player_x}) + dx;
    ny = $signed({2'b00, player_y}) + dy;
    if (nx[POS_W+1])      x_moved = '0;
    else if (nx > POS_MAX) x_moved = '1;
    else                  x_moved = nx[POS_W-1:0];
    if (ny[POS_W+1])      y_moved = '0;
    else if (ny > POS_MAX) y_moved = '1;
    else                  y_moved = ny[POS_W-1:0];
  end

`ifdef KART_COLLISION_EN
  logic                 collide;
  logic [POS_W-1:0]     c_ox;
  logic [POS_W-1:0]     c_oy;
  logic [POS_W-1:0]     c_dx;
  logic [POS_W-1:0]     c_dy;
  logic [POS_W:0]       c_dist;

  // contact test against every opponent that is still reporting
  always_comb begin
    collide = 1'b0;
    c_ox    = '0;
    c_oy    = '0;
    c_dx    = '0;
    c_dy    = '0;
    c_dist  = '0;
    for (int i = 0; i < NUM_OPP; i++) begin
      c_ox   = opponent_x[i*POS_W +: POS_W];
      c_oy   = opponent_y[i*POS_W +: POS_W];
      c_dx   = (player_x >= c_ox) ? player_x - c_ox : c_ox - player_x;
      c_dy   = (player_y >= c_oy) ? player_y - c_oy : c_oy - player_y;
      c_dist = {1'b0, c_dx} + {1'b0, c_dy};
      if (!opp_stale[i] && (c_dist < (POS_W+1)'(16))) collide = 1'b1;
    end
  end
`endif

  // final race-tick pose and the lap / win decision that follows from it
  always_comb begin
    race_x   = x_moved;
    race_y   = y_moved;
    race_spd = spd_next;
`ifdef KART_COLLISION_EN
    if (collide) begin
      race_x   = player_x;
      race_y   = player_y;
      race_spd = 3'd0;
    end
`endif
    lap_hit = (player_y >= LAP_Y) && (race_y < LAP_Y) &&
              (player_x >= LAP_X_LO) && (player_x <= LAP_X_HI);
    win     = lap_hit && (({1'b0, lap_count} + 3'd1) == LAPS_L);
  end

  // race state machine and local kart registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state            <= S_IDLE;
      cd_cnt           <= '0;
      player_x         <= START_X;
      player_y         <= START_Y;
      player_direction <= START_DIR;
      player_speed     <= 3'd0;
      lap_count        <= 2'd0;
    end else if (|r_opp_rst) begin
      state            <= S_IDLE;
      cd_cnt           <= '0;
      player_x         <= START_X;
      player_y         <= START_Y;
      player_direction <= START_DIR;
      player_speed     <= 3'd0;
      lap_count        <= 2'd0;
    end else begin
      case (state)
        S_IDLE: begin
          if (any_go || (tick && btnu)) begin
            state  <= S_COUNT;
            cd_cnt <= CD_W'(COUNT_FRAMES);
          end
        end
        S_COUNT: begin
          if (tick) begin
            cd_cnt <= cd_cnt - 1'b1;
            if (cd_cnt == CD_W'(1)) state <= S_RACE;
          end
        end
        S_RACE: begin
          if (tick) begin
            player_x         <= race_x;
            player_y         <= race_y;
            player_direction <= dir_next;
            player_speed     <= race_spd;
            if (lap_hit) lap_count <= lap_count + 2'd1;
          end
          if (tick && win)   state <= S_WON;
          else if (any_lost) state <= S_LOST;
        end
        default: state <= state;
      endcase
    end
  end

  // opponent position latches and per-channel staleness down-counters
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      opponent_x <= '0;
      opponent_y <= '0;
      opp_stale  <= '1;
      for (int i = 0; i < NUM_OPP; i++) stale_cnt[i] <= '0;
    end else begin
      for (int i = 0; i < NUM_OPP; i++) begin
        if (r_opp_valid[i]) begin
          opponent_x[i*POS_W +: POS_W] <= r_opp_x[i*POS_W +: POS_W];
          opponent_y[i*POS_W +: POS_W] <= r_opp_y[i*POS_W +: POS_W];
          stale_cnt[i]                 <= ST_W'(STALE_FRAMES);
          opp_stale[i]                 <= 1'b0;
        end else if (tick && (stale_cnt[i] != '0)) begin
          stale_cnt[i] <= stale_cnt[i] - 1'b1;
          if (stale_cnt[i] == ST_W'(1)) opp_stale[i] <= 1'b1;
        end
      end
    end
  end

endmodule
